// File: rtl/reg_file_sb_if.sv
// Bus bundle for reg_file_sb: write port, two read ports, scoreboard mark and busy status.
interface reg_file_sb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              we;
  logic [ADDR_W-1:0] adr_wrt;
  logic [DATA_W-1:0] data_in;
  logic              re;
  logic [ADDR_W-1:0] adr_srca;
  logic [ADDR_W-1:0] adr_srcb;
  logic [DATA_W-1:0] out_srca;
  logic [DATA_W-1:0] out_srcb;
  logic              mark_en;
  logic [ADDR_W-1:0] mark_adr;
  logic              busy_srca;
  logic              busy_srcb;
  logic              busy_any;

  modport master (
    output we, adr_wrt, data_in, re, adr_srca, adr_srcb, mark_en, mark_adr,
    input  out_srca, out_srcb, busy_srca, busy_srcb, busy_any
  );

  modport slave (
    input  we, adr_wrt, data_in, re, adr_srca, adr_srcb, mark_en, mark_adr,
    output out_srca, out_srcb, busy_srca, busy_srcb, busy_any
  );
endinterface

// File: rtl/reg_file_sb.sv
// Integer register file with two registered read ports, one write port and a busy scoreboard.
// Define REG_FILE_SB_BYPASS_EN to forward same-cycle write data/clear into the read path.
module reg_file_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input logic         clk,
  input logic         reset_n,
  reg_file_sb_if.slave bus
);
  localparam int NREGS = 2 ** ADDR_W;
  localparam bit ZR    = (ZERO_REG != 0);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic [NREGS-1:0]  busy_q, busy_d;
  logic [DATA_W-1:0] out_a_q, out_a_d;
  logic [DATA_W-1:0] out_b_q, out_b_d;

  logic wr_ok, mk_ok, zero_a, zero_b, byp_a, byp_b;
  logic [DATA_W-1:0] rd_a, rd_b;

  assign wr_ok  = bus.we      && !(ZR && (bus.adr_wrt  == '0));
  assign mk_ok  = bus.mark_en && !(ZR && (bus.mark_adr == '0));
  assign zero_a = ZR && (bus.adr_srca == '0);
  assign zero_b = ZR && (bus.adr_srcb == '0);

`ifdef REG_FILE_SB_BYPASS_EN
  assign byp_a = bus.we && (bus.adr_wrt == bus.adr_srca);
  assign byp_b = bus.we && (bus.adr_wrt == bus.adr_srcb);
`else
  assign byp_a = 1'b0;
  assign byp_b = 1'b0;
`endif

  // Mark is applied after write so a same-address mark leaves the register busy.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (wr_ok) begin
      regs_d[bus.adr_wrt] = bus.data_in;
      busy_d[bus.adr_wrt] = 1'b0;
    end
    if (mk_ok) busy_d[bus.mark_adr] = 1'b1;
  end

  always_comb begin
    rd_a = byp_a ? bus.data_in : regs_q[bus.adr_srca];
    rd_b = byp_b ? bus.data_in : regs_q[bus.adr_srcb];
    if (zero_a) rd_a = '0;
    if (zero_b) rd_b = '0;
    out_a_d = bus.re ? rd_a : out_a_q;
    out_b_d = bus.re ? rd_b : out_b_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      regs_q  <= '{default: '0};
      busy_q  <= '0;
      out_a_q <= '0;
      out_b_q <= '0;
    end else begin
      regs_q  <= regs_d;
      busy_q  <= busy_d;
      out_a_q <= out_a_d;
      out_b_q <= out_b_d;
    end
  end

  assign bus.out_srca  = out_a_q;
  assign bus.out_srcb  = out_b_q;
  assign bus.busy_srca = busy_q[bus.adr_srca] & ~zero_a & ~byp_a;
  assign bus.busy_srcb = busy_q[bus.adr_srcb] & ~zero_b & ~byp_b;
  assign bus.busy_any  = |busy_q;
endmodule

// File: tb/tb_reg_file_sb.sv
// Directed self-checking bench for reg_file_sb (default parameters).
module tb_reg_file_sb;
  logic clk;
  logic reset_n;
  int   n_cmp;
  int   n_err;

  reg_file_sb_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  reg_file_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.we = 0; bus.mark_en = 0; bus.re = 0;
  endtask

  task automatic test_reset();
    #1;
    n_cmp++; if (bus.out_srca !== 32'h0) begin n_err++; $display("FAIL reset_out_a got=%h exp=%h", bus.out_srca, 32'h0); end
    n_cmp++; if (bus.busy_any !== 1'b0) begin n_err++; $display("FAIL reset_busy_any got=%b exp=0", bus.busy_any); end
    #3 reset_n = 1;
    // write r3, mark r4
    bus.we = 1; bus.adr_wrt = 5'd3; bus.data_in = 32'hDEADBEEF;
    bus.mark_en = 1; bus.mark_adr = 5'd4;
    tick();
    idle();
    bus.re = 1; bus.adr_srca = 5'd3; bus.adr_srcb = 5'd3;
    tick();
    n_cmp++; if (bus.out_srca !== 32'hDEADBEEF) begin n_err++; $display("FAIL pre_reset_read got=%h exp=%h", bus.out_srca, 32'hDEADBEEF); end
    n_cmp++; if (bus.busy_any !== 1'b1) begin n_err++; $display("FAIL pre_reset_busy got=%b exp=1", bus.busy_any); end
    #2 reset_n = 0;
    #1;
    n_cmp++; if (bus.out_srca !== 32'h0 || bus.out_srcb !== 32'h0) begin n_err++; $display("FAIL async_reset_out got=%h/%h exp=0/0", bus.out_srca, bus.out_srcb); end
    n_cmp++; if (bus.busy_any !== 1'b0) begin n_err++; $display("FAIL async_reset_busy got=%b exp=0", bus.busy_any); end
    #3 reset_n = 1;
    tick();
    n_cmp++; if (bus.out_srca !== 32'h0) begin n_err++; $display("FAIL post_reset_r3 got=%h exp=0", bus.out_srca); end
    idle();
  endtask

  task automatic test_zero_reg();
    bus.we = 1; bus.adr_wrt = 5'd1; bus.data_in = 32'h11;
    tick();
    bus.adr_wrt = 5'd0; bus.data_in = 32'h12345678;
    bus.mark_en = 1; bus.mark_adr = 5'd0;
    bus.re = 1; bus.adr_srca = 5'd1; bus.adr_srcb = 5'd1;
    tick();
    n_cmp++; if (bus.out_srca !== 32'h11) begin n_err++; $display("FAIL zero_pre_r1 got=%h exp=%h", bus.out_srca, 32'h11); end
    idle();
    bus.re = 1; bus.adr_srca = 5'd0; bus.adr_srcb = 5'd0;
    #1;
    n_cmp++; if (bus.busy_srca !== 1'b0) begin n_err++; $display("FAIL zero_busy_a got=%b exp=0", bus.busy_srca); end
    n_cmp++; if (bus.busy_any !== 1'b0) begin n_err++; $display("FAIL zero_busy_any got=%b exp=0", bus.busy_any); end
    tick();
    n_cmp++; if (bus.out_srca !== 32'h0 || bus.out_srcb !== 32'h0) begin n_err++; $display("FAIL zero_read got=%h/%h exp=0/0", bus.out_srca, bus.out_srcb); end
    idle();
  endtask

  task automatic test_read_after_write();
    bus.we = 1; bus.adr_wrt = 5'd5; bus.data_in = 32'hA5A5A5A5;
    tick();
    idle();
    bus.re = 1; bus.adr_srca = 5'd5; bus.adr_srcb = 5'd5;
    tick();
    n_cmp++; if (bus.out_srca !== 32'hA5A5A5A5) begin n_err++; $display("FAIL raw_a got=%h exp=%h", bus.out_srca, 32'hA5A5A5A5); end
    n_cmp++; if (bus.out_srcb !== 32'hA5A5A5A5) begin n_err++; $display("FAIL raw_b got=%h exp=%h", bus.out_srcb, 32'hA5A5A5A5); end
    // independent ports
    bus.adr_srca = 5'd1; bus.adr_srcb = 5'd5;
    tick();
    n_cmp++; if (bus.out_srca !== 32'h11 || bus.out_srcb !== 32'hA5A5A5A5) begin n_err++; $display("FAIL indep got=%h/%h exp=%h/%h", bus.out_srca, bus.out_srcb, 32'h11, 32'hA5A5A5A5); end
    idle();
  endtask

  task automatic test_same_cycle();
    logic [31:0] exp_same;
`ifdef REG_FILE_SB_BYPASS_EN
    exp_same = 32'h2;
`else
    exp_same = 32'h1;
`endif
    bus.we = 1; bus.adr_wrt = 5'd7; bus.data_in = 32'h1;
    tick();
    bus.data_in = 32'h2;
    bus.re = 1; bus.adr_srca = 5'd7; bus.adr_srcb = 5'd7;
    tick();
    n_cmp++; if (bus.out_srca !== exp_same || bus.out_srcb !== exp_same) begin n_err++; $display("FAIL same_cycle got=%h/%h exp=%h", bus.out_srca, bus.out_srcb, exp_same); end
    bus.we = 0;
    tick();
    n_cmp++; if (bus.out_srca !== 32'h2) begin n_err++; $display("FAIL reread got=%h exp=%h", bus.out_srca, 32'h2); end
    idle();
  endtask

  task automatic test_stall();
    for (int i = 0; i < 3; i++) begin
      bus.re = 0;
      bus.adr_srca = 5'd5; bus.adr_srcb = 5'(i + 1);
      bus.we = 1; bus.adr_wrt = 5'd5; bus.data_in = 32'h77 + i;
      tick();
      n_cmp++; if (bus.out_srca !== 32'h2 || bus.out_srcb !== 32'h2) begin n_err++; $display("FAIL stall_%0d got=%h/%h exp=%h", i, bus.out_srca, bus.out_srcb, 32'h2); end
    end
    idle();
    bus.re = 1; bus.adr_srca = 5'd5;
    tick();
    n_cmp++; if (bus.out_srca !== 32'h79) begin n_err++; $display("FAIL stall_release got=%h exp=%h", bus.out_srca, 32'h79); end
    idle();
  endtask

  task automatic test_scoreboard();
    logic exp_wr_busy;
`ifdef REG_FILE_SB_BYPASS_EN
    exp_wr_busy = 1'b0;
`else
    exp_wr_busy = 1'b1;
`endif
    bus.adr_srca = 5'd9; bus.adr_srcb = 5'd9;
    bus.mark_en = 1; bus.mark_adr = 5'd9;
    #1;
    n_cmp++; if (bus.busy_srca !== 1'b0) begin n_err++; $display("FAIL mark_same_cycle got=%b exp=0", bus.busy_srca); end
    tick();
    bus.mark_en = 0;
    #1;
    n_cmp++; if (bus.busy_srca !== 1'b1 || bus.busy_srcb !== 1'b1) begin n_err++; $display("FAIL mark_busy got=%b/%b exp=1/1", bus.busy_srca, bus.busy_srcb); end
    n_cmp++; if (bus.busy_any !== 1'b1) begin n_err++; $display("FAIL mark_busy_any got=%b exp=1", bus.busy_any); end
    bus.we = 1; bus.adr_wrt = 5'd9; bus.data_in = 32'h99;
    bus.mark_en = 1; bus.mark_adr = 5'd9;
    tick();
    bus.we = 0; bus.mark_en = 0;
    #1;
    n_cmp++; if (bus.busy_srca !== 1'b1) begin n_err++; $display("FAIL mark_wins got=%b exp=1", bus.busy_srca); end
    bus.we = 1; bus.adr_wrt = 5'd9; bus.data_in = 32'h9A;
    #1;
    n_cmp++; if (bus.busy_srca !== exp_wr_busy) begin n_err++; $display("FAIL write_bypass_busy got=%b exp=%b", bus.busy_srca, exp_wr_busy); end
    tick();
    bus.we = 0;
    #1;
    n_cmp++; if (bus.busy_srca !== 1'b0 || bus.busy_any !== 1'b0) begin n_err++; $display("FAIL write_clear got=%b/%b exp=0/0", bus.busy_srca, bus.busy_any); end
    bus.re = 1;
    tick();
    n_cmp++; if (bus.out_srca !== 32'h9A) begin n_err++; $display("FAIL r9_data got=%h exp=%h", bus.out_srca, 32'h9A); end
    idle();
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    reset_n = 0;
    bus.we = 0; bus.adr_wrt = '0; bus.data_in = '0;
    bus.re = 0; bus.adr_srca = '0; bus.adr_srcb = '0;
    bus.mark_en = 0; bus.mark_adr = '0;
    test_reset();
    test_zero_reg();
    test_read_after_write();
    test_same_cycle();
    test_stall();
    test_scoreboard();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised successor to the core's integer register file: two registered read ports, one write port, and a per-register busy scoreboard for the issue stage. Read data is captured on the rising clock edge (one-cycle latency) with a hold/stall enable. An optional write-to-read bypass is compiled in by macro. Sits between decode (read, mark) and writeback (write, clear).

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; register count NREGS = 2**ADDR_W
- ZERO_REG, 1, 1 = register 0 reads as zero, ignores writes, and is never busy; 0 = register 0 is ordinary

- clk  in  1  clock; all state updates on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- we  in  1  write enable
- adr_wrt  in  ADDR_W  write address
- data_in  in  DATA_W  write data
- re  in  1  read enable; 0 holds both read outputs (stall)
- adr_srca  in  ADDR_W  read address A
- adr_srcb  in  ADDR_W  read address B
- out_srca  out  DATA_W  registered read data A
- out_srcb  out  DATA_W  registered read data B
- mark_en  in  1  set the busy bit of mark_adr (destination issued)
- mark_adr  in  ADDR_W  register to mark busy
- busy_srca  out  1  busy status of adr_srca (combinational)
- busy_srcb  out  1  busy status of adr_srcb (combinational)
- busy_any  out  1  OR of all busy bits (registered state)

## Operation
- Storage: NREGS x DATA_W array, plus an NREGS-bit busy vector.
- Write: at posedge, if we is 1, regs[adr_wrt] <= data_in and busy[adr_wrt] <= 0. With ZERO_REG=1 and adr_wrt=0, no effect.
- Mark: at posedge, if mark_en is 1, busy[mark_adr] <= 1. With ZERO_REG=1 and mark_adr=0, no effect.
- Mark and write to the same address in the same cycle: the register takes data_in and the busy bit ends at 1, because mark wins. Write clears the old producer and mark records the new one.
- Read: at posedge, if re is 1, out_srcX <= value(adr_srcX); if re is 0, the outputs hold. value() returns:
  - 0 when ZERO_REG=1 and the address is 0;
  - else data_in when bypass is enabled and we is 1 and adr_wrt equals the read address;
  - else the stored array contents as they were before this edge.
- Both read ports are independent. Identical addresses on both ports are legal and return identical data.
- busy_srcX = busy[adr_srcX], forced to 0 for address 0 when ZERO_REG=1. With bypass enabled, it is also forced to 0 when we is 1 and adr_wrt equals adr_srcX. mark_en never affects the same-cycle busy_srcX.
- busy_any is driven from the busy vector as it stands after the last edge.

## Timing
- Asynchronous reset (reset_n low):
  - every register and every busy bit go to 0;
  - out_srca, out_srcb and busy_any go to 0 immediately;
  - busy_srcX reads 0.
- Reset deassertion: state updates begin at the first rising edge with reset_n high.
- Reset asserted mid-operation: an in-flight write or mark on that edge is lost, and the outputs go to 0 without waiting for a clock edge.
- Read latency: address at edge N produces data valid after edge N and stable through edge N+1.
- Write-to-storage latency: 1 edge.
  - Without bypass, a read of the same address in the write cycle returns the old value; the new value is visible to a read issued the following cycle.
- Scoreboard latency: mark at edge N makes busy_srcX = 1 from after edge N.

## Configuration
- REG_FILE_SB_BYPASS_EN defined:
  - same-cycle write data is forwarded into the captured read data;
  - the same-cycle write suppresses busy_srcX for that address.
- Not defined:
  - no forwarding; reads see only pre-edge storage;
  - busy_srcX reflects only the stored busy bit;
  - the comparator logic is absent.

## Test plan
- Reset: drive reset_n=0 mid-cycle after writing 0xDEADBEEF to r3 -> outputs and busy_any are 0 immediately; a read of r3 after release returns 0.
- Zero register: write 0x12345678 to r0 and mark r0, then read r0 on both ports -> out = 0, busy_srca = 0, busy_any = 0.
- Read after write, both ports: write r5=0xA5A5A5A5, next cycle read srca=r5 and srcb=r5 -> both outputs are 0xA5A5A5A5 one edge later.
- Same-cycle write and read of r7 (old 0x1, new 0x2):
  - with REG_FILE_SB_BYPASS_EN, out = 0x2;
  - without it, out = 0x1, and out = 0x2 on a re-read the next cycle.
- Stall: re=0 for 3 cycles while addresses and writes change -> out_srca and out_srcb hold their previous values exactly.
- Scoreboard:
  - mark r9, then read r9 -> busy_srca = 1 and busy_any = 1;
  - write r9 and mark r9 on the same edge -> busy remains 1;
  - write r9 alone -> busy = 0 and busy_any = 0.
